jts16_rom_nslots: RTL and testbench

//  Generic read-only SDRAM bank front-end with NSLOTS client slots. It generalises the fixed 1/2/3-slot ROM banks.

---
 rtl/jts16_sdram_pkg.sv | 27 ++
 rtl/jts16_rom_nslots_if.sv | 15 +
 rtl/jts16_slot_cache.sv | 81 ++++++++
 rtl/jts16_rom_nslots.sv | 171 +++++++++++++++++
 tb/tb_jts16_rom_nslots.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/jts16_sdram_pkg.sv
// Shared definitions for the S16 SDRAM ROM bank front-ends: bank FSM
// state encoding, SDRAM lane geometry and slot-to-word address mapping.
package jts16_sdram_pkg;

  localparam int SDRAM_AW = 22;
  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } bank_state_e;

  // Map a slot address in DW-sized units to a 16-bit SDRAM word address,
  // wrapping modulo 2^22.
  function automatic logic [SDRAM_AW-1:0] word_addr(input logic [31:0] addr,
                                                   input int          dw);
    logic [31:0] w;
    case (dw)
      32:      w = addr << 1;
      16:      w = addr;
      default: w = addr >> 1;
    endcase
    return w[SDRAM_AW-1:0];
  endfunction

endpackage

// File: rtl/jts16_rom_nslots_if.sv
// One ba_rd/ba_ack/ba_dst/ba_rdy read lane of the SDRAM controller.
// master: the ROM bank issuing requests; slave: the SDRAM controller.
interface jts16_rom_nslots_if;
  import jts16_sdram_pkg::*;

  logic [SDRAM_AW-1:0] addr;
  logic                req;
  logic                ack;
  logic                dst;
  logic                rdy;
  logic [SDRAM_DW-1:0] data_read;

  modport master (output addr, req, input ack, dst, rdy, data_read);
  modport slave  (input addr, req, output ack, dst, rdy, data_read);
endinterface

// File: rtl/jts16_slot_cache.sv
// Single-entry last-word cache for one ROM client slot: tag/data/valid,
// hit compare, registered ok flag and, for 8-bit slots, byte select.
module jts16_slot_cache #(
  parameter int AW = 19,
  parameter int DW = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cs,
  input  logic                             clr,
  input  logic [AW-1:0]                    addr,
  input  logic                             fill_we,
  input  logic [AW-1:0]                    fill_addr,
  input  logic [((DW == 8) ? 16 : DW)-1:0] fill_data,
  output logic                             hit,
  output logic                             ok,
  output logic [DW-1:0]                    dout
);
  localparam int CW = (DW == 8) ? 16 : DW;

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [CW-1:0] data_q;
  logic          ok_q;
  logic          tag_hit;
  logic          fill_hit;

  // Tag compare; 8-bit slots share one 16-bit word between two addresses.
  always_comb begin
    if (DW == 8) begin
      tag_hit  = (tag_q[AW-1:1]     == addr[AW-1:1]);
      fill_hit = (fill_addr[AW-1:1] == addr[AW-1:1]);
    end else begin
      tag_hit  = (tag_q     == addr);
      fill_hit = (fill_addr == addr);
    end
  end

  assign hit = valid_q && tag_hit;

  // Cache entry update; an invalidate wins over a simultaneous fill.
  // NOTE: a single entry per slot is plain flops, so it takes the async
  // reset; a RAM-backed array would be left unreset and guarded by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (fill_we) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr;
      data_q  <= fill_data;
    end
  end

  // Registered ok: a fill landing this cycle decides on its own address,
  // otherwise the stored tag decides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ok_q <= 1'b0;
    else        ok_q <= cs && !clr && (fill_we ? fill_hit : hit);
  end

  assign ok = ok_q;

  if (DW == 8) begin : g_byte
    logic addr0_q;

    // Remember which byte the client asked for.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  addr0_q <= 1'b0;
      else if (cs) addr0_q <= addr[0];
    end

    assign dout = addr0_q ? data_q[15:8] : data_q[7:0];
  end else begin : g_word
    assign dout = data_q;
  end

endmodule

// File: rtl/jts16_rom_nslots.sv
// N-slot read-only SDRAM bank front-end: per-slot last-word caches, one
// arbiter/FSM issuing one burst at a time, offset adder, burst assembly.
// Optional build macro JTS16_ROM_RR_EN selects round-robin arbitration;
// otherwise fixed priority with slot 0 highest.
module jts16_rom_nslots
  import jts16_sdram_pkg::*;
#(
  parameter int                       NSLOTS  = 4,
  parameter int                       AW      = 19,
  parameter int                       DW      = 32,
  parameter logic [NSLOTS*SDRAM_AW-1:0] OFFSETS = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSLOTS-1:0]        slot_cs,
  input  logic [NSLOTS-1:0]        slot_clr,
  input  logic [NSLOTS*AW-1:0]     slot_addr,
  output logic [NSLOTS*DW-1:0]     slot_dout,
  output logic [NSLOTS-1:0]        slot_ok,
  jts16_rom_nslots_if.master       sdram
);
  localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam int CW = (DW == 8) ? SDRAM_DW : DW;

  bank_state_e         state_q, state_d;
  logic [SW-1:0]       sel_q;
  logic [SW-1:0]       pick;
  logic                pick_valid;
  logic [AW-1:0]       lat_addr_q;
  logic [SDRAM_AW-1:0] addr_q;
  logic                half_q;
  logic [15:0]         lo_q, hi_q;
  logic [15:0]         lo_v, hi_v;
  logic [CW-1:0]       fill_data;
  logic                load;
  logic                fill;
  logic [NSLOTS-1:0]   hit;
  logic [NSLOTS-1:0]   miss;
  logic [NSLOTS-1:0]   fill_we;

  assign miss = slot_cs & ~hit;

`ifdef JTS16_ROM_RR_EN
  logic [SW-1:0] last_q;
`endif

  // Arbiter: first missing slot, searching from the start slot upwards.
  always_comb begin
    int start;
    int idx;
    pick_valid = 1'b0;
    pick       = '0;
`ifdef JTS16_ROM_RR_EN
    start = int'(last_q) + 1;
    if (start >= NSLOTS) start = 0;
`else
    start = 0;
`endif
    for (int k = 0; k < NSLOTS; k++) begin
      idx = start + k;
      if (idx >= NSLOTS) idx = idx - NSLOTS;
      if (!pick_valid && miss[idx]) begin
        pick_valid = 1'b1;
        pick       = SW'(idx);
      end
    end
  end

  // Bank FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Bank FSM next state and strobes.
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    fill    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          load    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram.ack) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (sdram.rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the served slot, its address and the SDRAM word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      lat_addr_q <= '0;
      addr_q     <= '0;
    end else if (load) begin
      sel_q      <= pick;
      lat_addr_q <= slot_addr[int'(pick)*AW +: AW];
      addr_q     <= OFFSETS[int'(pick)*SDRAM_AW +: SDRAM_AW] +
                    word_addr(32'(slot_addr[int'(pick)*AW +: AW]), DW);
    end
  end

`ifdef JTS16_ROM_RR_EN
  // Remember the last slot served so the next search starts after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= SW'(NSLOTS - 1);
    else if (load) last_q <= pick;
  end
`endif

  // Burst word capture; 32-bit slots take the low half first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q <= 1'b0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else if (state_q != WAIT_DATA) begin
      half_q <= 1'b0;
    end else if (sdram.dst) begin
      if (half_q) hi_q <= sdram.data_read;
      else        lo_q <= sdram.data_read;
      if (DW == 32) half_q <= ~half_q;
    end
  end

  // Fill word, including a data word arriving together with data_rdy.
  always_comb begin
    lo_v = (sdram.dst && !half_q) ? sdram.data_read : lo_q;
    hi_v = (sdram.dst &&  half_q) ? sdram.data_read : hi_q;
    if (DW == 32) fill_data = CW'({hi_v, lo_v});
    else          fill_data = CW'(lo_v);
  end

  assign sdram.req  = (state_q == WAIT_ACK);
  assign sdram.addr = addr_q;

  for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
    assign fill_we[i] = fill && (sel_q == SW'(i));

    jts16_slot_cache #(
      .AW (AW),
      .DW (DW)
    ) u_cache (
      .clk       (clk),
      .rst_n     (rst_n),
      .cs        (slot_cs[i]),
      .clr       (slot_clr[i]),
      .addr      (slot_addr[i*AW +: AW]),
      .fill_we   (fill_we[i]),
      .fill_addr (lat_addr_q),
      .fill_data (fill_data),
      .hit       (hit[i]),
      .ok        (slot_ok[i]),
      .dout      (slot_dout[i*DW +: DW])
    );
  end

endmodule

// File: tb/tb_jts16_rom_nslots.sv
// Directed bench: a 3-slot 32-bit bank and a 1-slot 8-bit bank, with a
// small SDRAM controller model and a queue of expected burst addresses.
module tb_jts16_rom_nslots;

`ifdef JTS16_ROM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 3-slot bank
  logic [2:0]  cs32 = '0, clr32 = '0, ok32;
  logic [56:0] addr32 = '0;
  logic [95:0] dout32;
  jts16_rom_nslots_if if32 ();

  jts16_rom_nslots #(
    .NSLOTS  (3),
    .AW      (19),
    .DW      (32),
    .OFFSETS ({22'h20_0000, 22'h10_0000, 22'h00_0000})
  ) u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_cs   (cs32),
    .slot_clr  (clr32),
    .slot_addr (addr32),
    .slot_dout (dout32),
    .slot_ok   (ok32),
    .sdram     (if32.master)
  );

  // 8-bit, 1-slot bank
  logic [0:0]  cs8 = '0, clr8 = '0, ok8;
  logic [18:0] addr8 = '0;
  logic [7:0]  dout8;
  jts16_rom_nslots_if if8 ();

  jts16_rom_nslots #(
    .NSLOTS  (1),
    .AW      (19),
    .DW      (8),
    .OFFSETS (22'h0)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_cs   (cs8),
    .slot_clr  (clr8),
    .slot_addr (addr8),
    .slot_dout (dout8),
    .slot_ok   (ok8),
    .sdram     (if8.master)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [21:0] sb32[$];
  logic [21:0] sb8[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) for the 32-bit bank to raise its request.
  task automatic wait_req32(output bit got);
    int t = 0;
    while (if32.req !== 1'b1 && t < 40) begin step(); t++; end
    got = (if32.req === 1'b1);
    check("req32_raised", {63'd0, got}, 64'd1);
  endtask

  // Controller model for one 2-word burst; optional clr during data_rdy.
  task automatic serve32(input logic [15:0] w0, input logic [15:0] w1, input logic [2:0] clr_at_rdy);
    bit got;
    logic [21:0] exp;
    wait_req32(got);
    if (got) begin
      exp = (sb32.size() > 0) ? sb32.pop_front() : 22'h3F_FFFF;
      check("sdram_addr32", if32.addr, exp);
      step();
      check("req32_held", if32.req, 1);
      check("addr32_held", if32.addr, exp);
      if32.ack = 1'b1;
      step();
      if32.ack = 1'b0;
      check("req32_dropped", if32.req, 0);
      if32.dst = 1'b1; if32.data_read = w0;
      step();
      if32.data_read = w1; if32.rdy = 1'b1; clr32 = clr_at_rdy;
      step();
      if32.dst = 1'b0; if32.rdy = 1'b0; if32.data_read = '0; clr32 = '0;
    end
  endtask

  initial begin
    bit got;
    int t;
    logic [21:0] exp;
    if32.ack = 0; if32.dst = 0; if32.rdy = 0; if32.data_read = '0;
    if8.ack = 0;  if8.dst = 0;  if8.rdy = 0;  if8.data_read = '0;

    // Reset values
    step(); step();
    check("rst_ok32", ok32, 0);
    check("rst_dout32", dout32[63:0], 0);
    check("rst_req32", if32.req, 0);
    check("rst_addr32", if32.addr, 0);
    check("rst_ok8", ok8, 0);
    check("rst_req8", if8.req, 0);
    rst_n = 1'b1;

    // T1: slot1 miss at addr 5
    addr32[19 +: 19] = 19'd5; cs32 = 3'b010;
    sb32.push_back(22'h10_000A);
    serve32(16'h1111, 16'h2222, 3'b000);
    check("t1_ok", ok32, 3'b010);
    check("t1_dout", dout32[32 +: 32], 32'h2222_1111);

    // T2: ok follows cs; repeat access hits without a request
    cs32 = 3'b000; step();
    check("t2_ok_cs_low", ok32, 0);
    cs32 = 3'b010; step();
    check("t2_ok_hit", ok32, 3'b010);
    check("t2_no_req", if32.req, 0);
    step();
    check("t2_no_req_later", if32.req, 0);
    check("t2_dout", dout32[32 +: 32], 32'h2222_1111);
    cs32 = 3'b000;

    // slot0 fetch so slot0 is the last served
    addr32[0 +: 19] = 19'd2; cs32 = 3'b001;
    sb32.push_back(22'h00_0004);
    serve32(16'h3333, 16'h4444, 3'b000);
    check("s0_ok", ok32, 3'b001);
    check("s0_dout", dout32[0 +: 32], 32'h4444_3333);
    cs32 = 3'b000;

    // T3: slots 0 and 2 miss together
    addr32[0 +: 19] = 19'd9; addr32[38 +: 19] = 19'd1; cs32 = 3'b101;
    sb32.push_back(RR ? 22'h20_0002 : 22'h00_0012);
    sb32.push_back(RR ? 22'h00_0012 : 22'h20_0002);
    serve32(16'hA1A1, 16'hA2A2, 3'b000);
    check("t3_first_ok", ok32, RR ? 3'b100 : 3'b001);
    serve32(16'hB1B1, 16'hB2B2, 3'b000);
    check("t3_both_ok", ok32, 3'b101);
    check("t3_dout0", dout32[0 +: 32], RR ? 32'hB2B2_B1B1 : 32'hA2A2_A1A1);
    check("t3_dout2", dout32[64 +: 32], RR ? 32'hA2A2_A1A1 : 32'hB2B2_B1B1);
    cs32 = 3'b000;

    // T4: clr on slot1 together with its data_rdy, then refetch
    addr32[19 +: 19] = 19'd8; cs32 = 3'b010;
    sb32.push_back(22'h10_0010);
    serve32(16'h5A5A, 16'h6B6B, 3'b010);
    check("t4_ok_after_clr", ok32, 0);
    sb32.push_back(22'h10_0010);
    serve32(16'hC3C3, 16'hD4D4, 3'b000);
    check("t4_ok_refetch", ok32, 3'b010);
    check("t4_dout", dout32[32 +: 32], 32'hD4D4_C3C3);
    cs32 = 3'b000;

    // T5: 8-bit bank, addr 7 -> word 3, high byte; addr 6 hits, low byte
    addr8 = 19'd7; cs8 = 1'b1;
    sb8.push_back(22'h00_0003);
    t = 0;
    while (if8.req !== 1'b1 && t < 40) begin step(); t++; end
    check("t5_req8", if8.req, 1);
    exp = (sb8.size() > 0) ? sb8.pop_front() : 22'h3F_FFFF;
    check("t5_addr8", if8.addr, exp);
    if8.ack = 1'b1; step(); if8.ack = 1'b0;
    if8.dst = 1'b1; if8.rdy = 1'b1; if8.data_read = 16'hABCD; step();
    if8.dst = 1'b0; if8.rdy = 1'b0; if8.data_read = '0;
    check("t5_ok8", ok8, 1);
    check("t5_dout8_hi", dout8, 8'hAB);
    addr8 = 19'd6; step();
    check("t5_ok8_hit", ok8, 1);
    check("t5_dout8_lo", dout8, 8'hCD);
    check("t5_no_req8", if8.req, 0);
    cs8 = 1'b0;

    // T6: reset in WAIT_DATA, then a stale data_rdy after release
    addr32[38 +: 19] = 19'd3; cs32 = 3'b100;
    sb32.push_back(22'h20_0006);
    wait_req32(got);
    exp = (sb32.size() > 0) ? sb32.pop_front() : 22'h3F_FFFF;
    check("t6_addr32", if32.addr, exp);
    if32.ack = 1'b1; step(); if32.ack = 1'b0;
    if32.dst = 1'b1; if32.data_read = 16'h5555; step();
    if32.dst = 1'b0; cs32 = 3'b000; rst_n = 1'b0; step();
    check("t6_rst_req", if32.req, 0);
    check("t6_rst_ok", ok32, 0);
    check("t6_rst_addr", if32.addr, 0);
    check("t6_rst_dout", dout32, 96'd0);
    rst_n = 1'b1; if32.dst = 1'b1; if32.rdy = 1'b1; if32.data_read = 16'h9999; step();
    if32.dst = 1'b0; if32.rdy = 1'b0; if32.data_read = '0;
    check("t6_stale_req", if32.req, 0);
    check("t6_stale_ok", ok32, 0);
    check("t6_stale_dout", dout32, 96'd0);
    addr32[19 +: 19] = 19'd5; cs32 = 3'b010;
    sb32.push_back(22'h10_000A);
    serve32(16'h7777, 16'h8888, 3'b000);
    check("t6_refetch_ok", ok32, 3'b010);
    check("t6_refetch_dout", dout32[32 +: 32], 32'h8888_7777);
    cs32 = 3'b000;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
